// File: rtl/btn_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : btn_pulse_gen
// Purpose  : Per-channel sync, debounce and edge-selectable single-cycle pulse
//            generator. Define AUTO_REPEAT_EN to add hold-to-repeat pulses.
// Revision : 1.0 - initial release
// ============================================================================
module btn_pulse_gen #(
  parameter int CH            = 4,
  parameter int DB_CYCLES     = 16,
  parameter int EDGE_MODE     = 0,
  parameter int REPEAT_DELAY  = 1000,
  parameter int REPEAT_PERIOD = 200
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [CH-1:0] btn_in,
  input  logic          enable,
  output logic [CH-1:0] btn_pulse,
  output logic [CH-1:0] btn_level
);

  localparam int                 C_CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DB_CYCLES - 1);
  localparam logic               C_RISE_EN  = (EDGE_MODE == 0) || (EDGE_MODE == 2);
  localparam logic               C_FALL_EN  = (EDGE_MODE == 1) || (EDGE_MODE == 2);

  logic [CH-1:0]      sync1_q, sync1_d;
  logic [CH-1:0]      sync2_q, sync2_d;
  logic [CH-1:0]      stable_q, stable_d;
  logic [CH-1:0]      pulse_q, pulse_d;
  logic [C_CNT_W-1:0] cnt_q [CH];
  logic [C_CNT_W-1:0] cnt_d [CH];
  logic [CH-1:0]      w_accept;
  logic [CH-1:0]      w_rpt_fire;

  // Debounce: the new level is taken only after DB_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    sync1_d  = btn_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    w_accept = '0;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == C_CNT_LAST) begin
          w_accept[i] = 1'b1;
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < CH; i++) begin
      pulse_d[i] = enable & ((C_RISE_EN & w_accept[i] &  sync2_q[i]) |
                             (C_FALL_EN & w_accept[i] & ~sync2_q[i]) |
                             w_rpt_fire[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      pulse_q  <= '0;
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  if (EDGE_MODE != 1) begin : g_repeat
    localparam int C_RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int C_RPT_W   = $clog2(C_RPT_MAX + 1);
    localparam logic [C_RPT_W-1:0] C_DLY_LAST = C_RPT_W'(REPEAT_DELAY - 1);
    localparam logic [C_RPT_W-1:0] C_PER_LAST = C_RPT_W'(REPEAT_PERIOD - 1);

    logic [C_RPT_W-1:0] rpt_cnt_q [CH];
    logic [C_RPT_W-1:0] rpt_cnt_d [CH];
    logic [CH-1:0]      rpt_per_q, rpt_per_d;

    // Counter restarts on the press edge (stable still 0 there) and is held
    // clear whenever the debounced level is low or about to fall.
    always_comb begin
      w_rpt_fire = '0;
      rpt_per_d  = '0;
      for (int i = 0; i < CH; i++) begin
        rpt_cnt_d[i] = '0;
        if (stable_q[i] && !w_accept[i]) begin
          if (rpt_cnt_q[i] == (rpt_per_q[i] ? C_PER_LAST : C_DLY_LAST)) begin
            w_rpt_fire[i] = 1'b1;
            rpt_per_d[i]  = 1'b1;
          end else begin
            rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
            rpt_per_d[i] = rpt_per_q[i];
          end
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rpt_per_q <= '0;
        for (int i = 0; i < CH; i++) begin
          rpt_cnt_q[i] <= '0;
        end
      end else begin
        rpt_per_q <= rpt_per_d;
        for (int i = 0; i < CH; i++) begin
          rpt_cnt_q[i] <= rpt_cnt_d[i];
        end
      end
    end
  end else begin : g_no_repeat
    assign w_rpt_fire = '0;
  end
`else
  assign w_rpt_fire = '0;
`endif

  assign btn_pulse = pulse_q;
  assign btn_level = stable_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_pulse_gen
// Purpose  : Self-checking bench for btn_pulse_gen (three edge modes plus a
//            repeat-configured instance), vector table plus scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_pulse_gen;

  localparam int DB  = 4;
  localparam int LAT = DB + 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [3:0] btn;
  logic [3:0] btn_r;
  logic [3:0] pls [4];
  logic [3:0] lvl [4];

  always #5 clk = ~clk;

  btn_pulse_gen #(.CH(4), .DB_CYCLES(DB), .EDGE_MODE(0)) u_m0 (
    .clk(clk), .reset_n(reset_n), .btn_in(btn), .enable(enable),
    .btn_pulse(pls[0]), .btn_level(lvl[0]));

  btn_pulse_gen #(.CH(4), .DB_CYCLES(DB), .EDGE_MODE(1)) u_m1 (
    .clk(clk), .reset_n(reset_n), .btn_in(btn), .enable(enable),
    .btn_pulse(pls[1]), .btn_level(lvl[1]));

  btn_pulse_gen #(.CH(4), .DB_CYCLES(DB), .EDGE_MODE(2)) u_m2 (
    .clk(clk), .reset_n(reset_n), .btn_in(btn), .enable(enable),
    .btn_pulse(pls[2]), .btn_level(lvl[2]));

  btn_pulse_gen #(.CH(4), .DB_CYCLES(DB), .EDGE_MODE(0),
                  .REPEAT_DELAY(20), .REPEAT_PERIOD(5)) u_rpt (
    .clk(clk), .reset_n(reset_n), .btn_in(btn_r), .enable(enable),
    .btn_pulse(pls[3]), .btn_level(lvl[3]));

  typedef struct {
    int         cyc;
    logic [3:0] mask;
  } ev_t;

  typedef struct {
    logic [3:0] btn;
    logic       en;
    int         hold;
    logic [3:0] p0;
    logic [3:0] p1;
    logic [3:0] p2;
    logic [3:0] lvl;
  } vec_t;

  ev_t sbq [4][$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  cyc    = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push(input int d, input int at, input logic [3:0] m);
    ev_t e;
    e.cyc  = at;
    e.mask = m;
    if (m != 4'b0000) sbq[d].push_back(e);
  endtask

  // One clock: advance the cycle count, then compare every pulse output
  // against the scoreboard on the falling edge.
  task automatic tick();
    logic [3:0] e_mask;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      e_mask = 4'b0000;
      if (sbq[d].size() > 0 && sbq[d][0].cyc == cyc) begin
        e_mask = sbq[d][0].mask;
        void'(sbq[d].pop_front());
      end
      chk($sformatf("pulse_dut%0d", d), int'(pls[d]), int'(e_mask));
    end
  endtask

  initial begin
    vec_t tbl [13];
    int   c0;
    int   p;

    reset_n = 1'b0;
    enable  = 1'b1;
    btn     = 4'b0000;
    btn_r   = 4'b0000;

    //            btn      en    hold p0       p1       p2       lvl
    tbl[0]  = '{4'b0100, 1'b1, 8, 4'b0100, 4'b0000, 4'b0100, 4'b0100};
    tbl[1]  = '{4'b0101, 1'b1, 3, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
    tbl[2]  = '{4'b0100, 1'b1, 8, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
    tbl[3]  = '{4'b0000, 1'b1, 8, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
    tbl[4]  = '{4'b1011, 1'b1, 8, 4'b1011, 4'b0000, 4'b1011, 4'b1011};
    tbl[5]  = '{4'b1001, 1'b0, 8, 4'b0000, 4'b0000, 4'b0000, 4'b1001};
    tbl[6]  = '{4'b1011, 1'b0, 8, 4'b0000, 4'b0000, 4'b0000, 4'b1011};
    tbl[7]  = '{4'b1011, 1'b1, 8, 4'b0000, 4'b0000, 4'b0000, 4'b1011};
    tbl[8]  = '{4'b1001, 1'b1, 8, 4'b0000, 4'b0010, 4'b0010, 4'b1001};
    tbl[9]  = '{4'b1011, 1'b1, 8, 4'b0010, 4'b0000, 4'b0010, 4'b1011};
    tbl[10] = '{4'b0000, 1'b1, 8, 4'b0000, 4'b1011, 4'b1011, 4'b0000};
    tbl[11] = '{4'b0001, 1'b1, 4, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
    tbl[12] = '{4'b0000, 1'b1, 8, 4'b0000, 4'b0001, 4'b0001, 4'b0000};

    // Outputs held low while in reset
    repeat (2) tick();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset_level_dut%0d", d), int'(lvl[d]), 0);
    end
    reset_n = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 13; i++) begin
      btn    = tbl[i].btn;
      enable = tbl[i].en;
      c0     = cyc;
      push(0, c0 + LAT, tbl[i].p0);
      push(1, c0 + LAT, tbl[i].p1);
      push(2, c0 + LAT, tbl[i].p2);
      repeat (tbl[i].hold) tick();
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("level_vec%0d_dut%0d", i, d), int'(lvl[d]), int'(tbl[i].lvl));
      end
    end
    repeat (4) tick();

    // Press, hold 10 cycles, release: both-edge pulses 10 apart
    btn = 4'b0001;
    push(0, cyc + LAT, 4'b0001);
    push(2, cyc + LAT, 4'b0001);
    repeat (10) tick();
    btn = 4'b0000;
    push(1, cyc + LAT, 4'b0001);
    push(2, cyc + LAT, 4'b0001);
    repeat (10) tick();

    // Asynchronous reset while channel 3 is mid-count
    btn = 4'b0111;
    push(0, cyc + LAT, 4'b0111);
    push(2, cyc + LAT, 4'b0111);
    repeat (8) tick();
    btn = 4'b1111;
    repeat (4) tick();
    #2;
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("async_rst_level_dut%0d", d), int'(lvl[d]), 0);
      chk($sformatf("async_rst_pulse_dut%0d", d), int'(pls[d]), 0);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    push(0, cyc + LAT, 4'b1111);
    push(2, cyc + LAT, 4'b1111);
    repeat (8) tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("post_rst_level_dut%0d", d), int'(lvl[d]), 15);
    end
    btn = 4'b0000;
    push(1, cyc + LAT, 4'b1111);
    push(2, cyc + LAT, 4'b1111);
    repeat (8) tick();

    // Hold-to-repeat on the repeat-configured instance
    btn_r = 4'b0001;
    p     = cyc + LAT;
    push(3, p, 4'b0001);
`ifdef AUTO_REPEAT_EN
    for (int k = 20; k <= 40; k += 5) push(3, p + k, 4'b0001);
`endif
    while (cyc < p + 36) tick();
    chk("rpt_level_held", int'(lvl[3]), 1);
    btn_r = 4'b0000;
    repeat (30) tick();
    chk("rpt_level_released", int'(lvl[3]), 0);

    for (int d = 0; d < 4; d++) begin
      chk($sformatf("sb_drain_dut%0d", d), sbq[d].size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
